// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // One in-flight branch prediction, kept until the branch resolves
    typedef struct packed {
        logic        taken;
        logic [31:0] fallthrough;
        logic [31:0] target;
    } pred_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    localparam int          BRANCH_OPC_MIN = 4;
    localparam int          BRANCH_OPC_MAX = 7;
    localparam logic [31:0] PC_STEP        = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Fetch-side bus: BHT lookup results, branch resolution from
//               decode/execute, and the PC/flush/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;

    logic        stall;
    logic        fetch_is_branch;
    logic        pred_hit;
    logic        prediction;
    logic [31:0] targetpc;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic [31:0] pc;
    logic [3:0]  index;
    logic        flush;
    logic        q_full;
    logic [15:0] mispredict_count;

    // Environment side: drives fetch/resolve inputs, observes PC and status
    modport master (
        output stall, fetch_is_branch, pred_hit, prediction, targetpc,
               resolve_valid, resolve_taken, resolve_target,
        input  pc, index, flush, q_full, mispredict_count
    );

    // Fetch PC unit side
    modport slave (
        input  stall, fetch_is_branch, pred_hit, prediction, targetpc,
               resolve_valid, resolve_taken, resolve_target,
        output pc, index, flush, q_full, mispredict_count
    );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit_pred_queue.sv
`default_nettype none
// ============================================================================
// Module      : pred_queue
// Description : In-order FIFO of branch predictions. Pointers carry one extra
//               wrap bit so full and empty are distinguishable. Clear wins
//               over push.
// Revision    : 1.0 - initial release
// ============================================================================
module pred_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        push,
    input  wire logic        pop,
    input  wire logic        clear,
    input  wire pred_entry_t wr_data,
    output logic             full,
    output logic             empty,
    output pred_entry_t      head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    pred_entry_t  mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push is legal when full
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear empties the queue and drops any push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage write
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch-stage PC generator. Selects next PC from the BHT
//               prediction or PC+4, records branch predictions, checks them
//               against resolved outcomes and redirects with a flush window
//               on a mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          QDEPTH       = 4,
    parameter int          FLUSH_CYCLES = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_pc_unit_if.slave bus
);

    localparam int             FCW        = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(1);

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [FCW-1:0] flush_cnt;
    logic [FCW-1:0] flush_cnt_next;
    logic           flush_reg;
    logic           flush_d;
    logic           run_active;

    logic [31:0]    pc_reg;
    logic [31:0]    pc_next;
    logic [31:0]    pc_plus4;
    logic [15:0]    mispredict_cnt;

    logic           eff_taken;
    logic           q_full;
    logic           q_empty;
    logic           q_push;
    logic           q_pop;
    pred_entry_t    q_head;
    pred_entry_t    q_wr_data;
    logic           mispredict;
    logic           redirect;
    logic           adv;

    assign eff_taken  = bus.pred_hit & bus.prediction;
    assign pc_plus4   = pc_reg + PC_STEP;

    // Resolves are only consumed while running and when a branch is in flight
    assign q_pop      = bus.resolve_valid && run_active && !q_empty;
    assign mispredict = q_pop &&
                        ((bus.resolve_taken != q_head.taken) ||
                         (bus.resolve_taken && q_head.taken &&
                          (bus.resolve_target != q_head.target)));
    assign redirect   = mispredict;
    assign adv        = !bus.stall && !(q_full && !q_pop) && !redirect;
    assign q_push     = adv && bus.fetch_is_branch;

    // Prediction record for the branch being fetched this cycle
    always_comb begin
        q_wr_data             = '0;
        q_wr_data.taken       = eff_taken;
        q_wr_data.fallthrough = pc_plus4;
        q_wr_data.target      = bus.targetpc;
    end

    pred_queue #(
        .DEPTH (QDEPTH)
    ) u_pred_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (q_push),
        .pop     (q_pop),
        .clear   (redirect),
        .wr_data (q_wr_data),
        .full    (q_full),
        .empty   (q_empty),
        .head    (q_head)
    );

    // Next-PC select: redirect beats stall, queue full and prediction
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = bus.resolve_taken ? bus.resolve_target : q_head.fallthrough;
        end else if (adv) begin
            pc_next = (eff_taken && bus.fetch_is_branch) ? bus.targetpc : pc_plus4;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= RESET_PC;
        else     pc_reg <= pc_next;
    end

    // Saturating mispredict counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (redirect && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

    // FSM state register with flush window counter and registered flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            flush_reg <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            flush_reg <= flush_d;
        end
    end

    // FSM next state: redirect opens the window, it closes after the last count
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (redirect) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_next     = RUN;
                    flush_cnt_next = '0;
                end else begin
                    flush_cnt_next = flush_cnt - FCW'(1);
                end
            end
            default: begin
                state_next     = RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // FSM outputs: resolve acceptance now, flush value for the next cycle
    always_comb begin
        run_active = (state == RUN);
        flush_d    = (state_next == FLUSH);
    end

    assign bus.pc               = pc_reg;
    assign bus.index            = {1'b0, pc_reg[4:2]};
    assign bus.flush            = flush_reg;
    assign bus.q_full           = q_full;
    assign bus.mispredict_count = mispredict_cnt;

endmodule
`default_nettype wire
